// File: rtl/spi_status_unit.sv
// spi_status_unit
//
// Status/flag register for the SPI interface. It samples the sender and
// receiver FIFO state plus the host/shift-engine strobes on every rising
// clock edge and produces a registered 8-bit status word.
//
// Status bit map (L = live registered copy, S = sticky, write-1-to-clear):
//   [0] TX_OVF    S  host wrote while the sender FIFO was full
//   [1] RX_UNF    S  host read while the receiver FIFO was empty
//   [2] RX_FULL   L  receiver FIFO full
//   [3] RX_OVF    S  shift engine pushed while the receiver FIFO was full
//   [4] TX_EMPTY  L  sender FIFO empty
//   [5] TX_DONE   S  sender FIFO just became empty
//   [6] RX_AVAIL  L  receiver FIFO not empty
//   [7] CONN_FAIL S  link-fail input high for FAIL_FILTER consecutive samples
//
// Ports:
//   i_s_clk                  clock, everything sampled on the rising edge
//   i_clr                    asynchronous active-high reset
//   i_sender_full_state      sender FIFO full
//   i_sender_empty_state     sender FIFO empty
//   i_sender_write           host write strobe into the sender FIFO
//   i_receiver_full_state    receiver FIFO full
//   i_receiver_empty_state   receiver FIFO empty
//   i_receiver_read          host read strobe from the receiver FIFO
//   i_receiver_push          shift engine push strobe into the receiver FIFO
//   i_connection_failed_state raw link-fail indication (may glitch)
//   i_flag_clr_wr            sticky-flag clear strobe
//   i_flag_clr_mask          write-1-to-clear mask for the sticky flags
//   i_cnt_clr                synchronous clear of the error counter
//   i_irq_en                 per-bit interrupt enable
//   o_status                 registered status word
//   o_err_cnt                saturating error-event counter
//   o_irq                    OR of the enabled status bits
module spi_status_unit #(
    parameter int CNT_W       = 4,
    parameter int FAIL_FILTER = 4
) (
    input  logic             i_s_clk,
    input  logic             i_clr,
    input  logic             i_sender_full_state,
    input  logic             i_sender_empty_state,
    input  logic             i_sender_write,
    input  logic             i_receiver_full_state,
    input  logic             i_receiver_empty_state,
    input  logic             i_receiver_read,
    input  logic             i_receiver_push,
    input  logic             i_connection_failed_state,
    input  logic             i_flag_clr_wr,
    input  logic [7:0]       i_flag_clr_mask,
    input  logic             i_cnt_clr,
    input  logic [7:0]       i_irq_en,
    output logic [7:0]       o_status,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_irq
);

    // Positions of the sticky flags; mask bits outside this set are ignored.
    localparam logic [7:0]       STICKY_BITS = 8'hAB;
    localparam logic [7:0]       FAIL_MAX    = 8'(FAIL_FILTER);
    localparam logic [CNT_W+1:0] CNT_MAX     = {2'b00, {CNT_W{1'b1}}};

    logic [7:0]       r_status;
    logic [CNT_W-1:0] r_errCnt;
    logic [7:0]       r_failCnt;
    logic             r_prevEmpty;

    logic             w_setTxOvf;
    logic             w_setRxUnf;
    logic             w_setRxOvf;
    logic             w_setTxDone;
    logic             w_setConnFail;
    logic [7:0]       w_failCntNext;
    logic [7:0]       w_setMask;
    logic [7:0]       w_clrMask;
    logic [7:0]       w_liveBits;
    logic [7:0]       w_statusNext;
    logic [1:0]       w_events;
    logic [CNT_W+1:0] w_errSum;
    logic [CNT_W-1:0] w_errNext;

    // Set conditions, fail filter and the next status word. Sticky bits
    // are cleared first and then OR-ed with their set condition, so a set
    // in the same cycle as a clear request wins.
    always_comb begin
        w_setTxOvf  = i_sender_write  & i_sender_full_state;
        w_setRxUnf  = i_receiver_read & i_receiver_empty_state;
        w_setRxOvf  = i_receiver_push & i_receiver_full_state;
        w_setTxDone = i_sender_empty_state & ~r_prevEmpty;

        // Consecutive-high counter; it holds at FAIL_MAX so that a cleared
        // CONN_FAIL keeps re-setting while the link stays failed.
        w_failCntNext = 8'd0;
        if (i_connection_failed_state) begin
            if (r_failCnt >= FAIL_MAX) begin
                w_failCntNext = FAIL_MAX;
            end else begin
                w_failCntNext = r_failCnt + 8'd1;
            end
        end
        w_setConnFail = i_connection_failed_state & (w_failCntNext == FAIL_MAX);

        w_setMask  = {w_setConnFail, 1'b0, w_setTxDone, 1'b0,
                      w_setRxOvf, 1'b0, w_setRxUnf, w_setTxOvf};
        w_clrMask  = i_flag_clr_wr ? (i_flag_clr_mask & STICKY_BITS) : 8'h00;
        w_liveBits = {1'b0, ~i_receiver_empty_state, 1'b0, i_sender_empty_state,
                      1'b0, i_receiver_full_state, 2'b00};

        w_statusNext = (r_status & STICKY_BITS & ~w_clrMask) | w_setMask | w_liveBits;

        // Error events of this cycle are added even when the counter is
        // being cleared, so nothing is lost; the sum saturates at all ones.
        w_events = {1'b0, w_setTxOvf} + {1'b0, w_setRxUnf} + {1'b0, w_setRxOvf};
        w_errSum = (i_cnt_clr ? {(CNT_W+2){1'b0}} : {2'b00, r_errCnt})
                   + {{CNT_W{1'b0}}, w_events};
        if (w_errSum > CNT_MAX) begin
            w_errNext = CNT_MAX[CNT_W-1:0];
        end else begin
            w_errNext = w_errSum[CNT_W-1:0];
        end
    end

    // State registers. The previous-empty sample resets to 1 so that an
    // already-empty sender FIFO does not look like a fresh TX_DONE edge.
    always_ff @(posedge i_s_clk or posedge i_clr) begin
        if (i_clr) begin
            r_status    <= 8'h30;
            r_errCnt    <= '0;
            r_failCnt   <= 8'd0;
            r_prevEmpty <= 1'b1;
        end else begin
            r_status    <= w_statusNext;
            r_errCnt    <= w_errNext;
            r_failCnt   <= w_failCntNext;
            r_prevEmpty <= i_sender_empty_state;
        end
    end

    assign o_status  = r_status;
    assign o_err_cnt = r_errCnt;
    assign o_irq     = |(r_status & i_irq_en);

endmodule

// File: doc/spi_status_unit.md
# spi_status_unit

Parametrised status/flag register for the SPI interface, the successor to the fixed 8-bit status combiner. It samples sender/receiver FIFO state and strobes on `S_CLK`, and produces a registered 8-bit `STATUS` word. The word combines live flags and sticky error/event flags (write-1-to-clear), plus a saturating error counter, a debounced connection-fail flag and a maskable interrupt. It sits between the sender/receiver FIFOs and the host register interface.

## Interface
- `CNT_W`, 4: width of error counter `ERR_CNT`; legal 2..16.
- `FAIL_FILTER`, 4: consecutive high samples of `CONNECTION_FAILED_STATE` needed to set bit 7; legal 1..255.
- `S_CLK`  in  1  sole clock; everything is sampled on the rising edge.
- `CLR`  in  1  reset, asynchronous, active-high.
- `SENDER_FULL_STATE`  in  1  sender FIFO full.
- `SENDER_EMPTY_STATE`  in  1  sender FIFO empty.
- `SENDER_WRITE`  in  1  host write strobe into sender FIFO, one cycle per byte.
- `RECEIVER_FULL_STATE`  in  1  receiver FIFO full.
- `RECEIVER_EMPTY_STATE`  in  1  receiver FIFO empty.
- `RECEIVER_READ`  in  1  host read strobe from receiver FIFO.
- `RECEIVER_PUSH`  in  1  shift engine pushes a received byte into the receiver FIFO.
- `CONNECTION_FAILED_STATE`  in  1  raw link-fail indication; may glitch.
- `FLAG_CLR_WR`  in  1  clear strobe for sticky flags.
- `FLAG_CLR_MASK`  in  8  write-1-to-clear mask; only used when `FLAG_CLR_WR`=1.
- `CNT_CLR`  in  1  synchronous clear of `ERR_CNT`.
- `IRQ_EN`  in  8  per-bit interrupt enable.
- `STATUS`  out  8  status word, registered.
- `ERR_CNT`  out  `CNT_W`  saturating error-event counter, registered.
- `IRQ`  out  1  interrupt, equal to `|(STATUS & IRQ_EN)`.

## Operation
- Bit map of `STATUS`. L = live, registered copy of an input. S = sticky.
  - [0] TX_OVF S: set when `SENDER_WRITE` & `SENDER_FULL_STATE`.
  - [1] RX_UNF S: set when `RECEIVER_READ` & `RECEIVER_EMPTY_STATE`.
  - [2] RX_FULL L: follows `RECEIVER_FULL_STATE`.
  - [3] RX_OVF S: set when `RECEIVER_PUSH` & `RECEIVER_FULL_STATE`.
  - [4] TX_EMPTY L: follows `SENDER_EMPTY_STATE`.
  - [5] TX_DONE S: set on a 0→1 transition of `SENDER_EMPTY_STATE`, detected against its previous-cycle sample.
  - [6] RX_AVAIL L: equals `~RECEIVER_EMPTY_STATE`.
  - [7] CONN_FAIL S: set by the fail filter.
- Sticky clear: at an edge with `FLAG_CLR_WR`=1, sticky bit i clears if `FLAG_CLR_MASK[i]`=1. Mask bits 2, 4 and 6 are ignored.
- If a sticky bit has a set condition and a clear request in the same cycle, set wins.
- Fail filter:
  - An internal counter counts consecutive cycles with `CONNECTION_FAILED_STATE`=1, saturating at `FAIL_FILTER`.
  - Any low sample resets the counter to 0.
  - Bit 7 sets at the edge where the counter reaches `FAIL_FILTER`, i.e. the Nth consecutive high sample.
  - With `FAIL_FILTER`=1 it sets on the first high sample.
  - A clear of bit 7 while the input is still high and the counter is saturated: the bit re-sets on the next edge.
- `ERR_CNT`:
  - Each edge adds the number of error events in that cycle (bits 0, 1, 3 set conditions, 0..3).
  - Saturates at 2^`CNT_W`−1 and never wraps.
  - `CNT_CLR`=1 loads 0, plus this cycle's events; events are not lost.
  - Counting is independent of sticky-flag clears.
- Previous-sample register for the TX_DONE edge detector resets to 1, so there is no spurious TX_DONE after reset.

## Timing
- Reset (`CLR`=1, asynchronous) values:
  - `STATUS`=8'h30 (TX_EMPTY=1, TX_DONE=1).
  - `ERR_CNT`=0, fail counter 0, edge-detector previous sample 1.
  - `IRQ` = `|(8'h30 & IRQ_EN)`.
- Deassertion of `CLR` is taken at the next rising edge. Reset mid-operation discards all flags and counts immediately.
- Latency: an input condition present before edge k is visible on `STATUS`/`ERR_CNT` after edge k (1 cycle).
- `IRQ` is combinational from registered `STATUS` and `IRQ_EN`, so it follows the same edge as `STATUS`. An `IRQ_EN` change reflects in the same cycle.
- Strobes are level-sampled per cycle: a strobe held N cycles counts as N events.

## Test plan
- Reset: assert `CLR` asynchronously mid-cycle → `STATUS`=8'h30 and `ERR_CNT`=0 immediately. With `IRQ_EN`=8'h20, `IRQ`=1.
- TX overflow: `SENDER_FULL_STATE`=1 with `SENDER_WRITE` high for 3 cycles → bit 0=1 and `ERR_CNT`=3. Then `FLAG_CLR_WR` with mask 8'h01 → bit 0=0, `ERR_CNT` stays 3.
- Set/clear collision: `RECEIVER_PUSH` & `RECEIVER_FULL_STATE` in the same cycle as a clear with mask 8'h08 → bit 3 stays 1. A clear in the following quiet cycle → bit 3=0.
- Fail filter (`FAIL_FILTER`=4): `CONNECTION_FAILED_STATE` high 3 cycles, low 1, high 4 → bit 7=0 until after the 4th consecutive high edge, then 1.
- Saturation (`CNT_W`=2): 5 single events → `ERR_CNT`=3. A `CNT_CLR` concurrent with an RX_UNF event → `ERR_CNT`=1.
- TX_DONE: clear bit 5, drive `SENDER_EMPTY_STATE` 1→0→1 → bit 5 re-sets one edge after the rise. Bit 4 tracks the input with 1-cycle lag. Mask 8'h14 has no effect on bits 2 and 4.
